clock_enable_gen: RTL and testbench
===================================

// Module: clock_enable_gen
// PURPOSE
//  Lock-qualified multi-channel NCO clock-enable generator in the master PLL output domain.
//  Per channel: phase accumulator giving one-cycle ce pulses and a square wave at f = f_clk*FTW/2^ACC_WIDTH.
//  Holds all channels idle until PLL lock has been stable; drops to idle and flags on lock loss.
//  Frequency words update glitch-free at each channel's own wrap; phase_sync realigns all channels.
// PARAMETERS
//  CHANNELS     4     number of NCO channels (>=2)
//  ACC_WIDTH    24    phase accumulator / tuning word width (>=4)
//  LOCK_HOLD    1024  consecutive synced-lock-high cycles required before RUN (>=1)
//  SYNC_STAGES  2     flip-flop stages synchronising pll_lock (>=2)
//  CH_W         2     channel select width, = $clog2(CHANNELS)
// PORTS
//  clk          in   1            PLL output clock; only clock
//  rst          in   1            asynchronous, active-high reset
//  pll_lock     in   1            raw PLL LOCK, asynchronous to clk
//  wr_en        in   1            tuning word write strobe
//  wr_ch        in   CH_W         target channel
//  wr_ftw       in   ACC_WIDTH    new frequency tuning word
//  phase_sync   in   1            pulse: zero all accumulators
//  lost_clear   in   1            clears lock_lost
//  ready        out  1            high in RUN only
//  lock_lost    out  1            sticky: lock dropped while in RUN
//  pending      out  CHANNELS     per channel: written word not yet applied
//  ce           out  CHANNELS     one-cycle enable pulse per accumulator wrap
//  sq           out  CHANNELS     accumulator MSB (50% duty for power-of-two periods)
// BEHAVIOUR
//  Reset: state=WAIT_LOCK, sync chain, counter, acc, ftw, shadow all 0; every output 0.
//  lock_s = pll_lock after SYNC_STAGES flops. States:
//   WAIT_LOCK: cnt=0; lock_s=1 -> SETTLE.
//   SETTLE: cnt++ each cycle lock_s=1; lock_s=0 -> WAIT_LOCK; cnt reaches LOCK_HOLD-1 with lock_s=1 -> RUN.
//   RUN: ready=1; lock_s=0 -> WAIT_LOCK, lock_lost<=1.
//  ready first high exactly SYNC_STAGES+LOCK_HOLD edges after first edge sampling pll_lock=1.
//  Outside RUN: acc held 0, ce=0, sq=0; writes load ftw and shadow directly, pending stays 0.
//  RUN, per channel i each edge: {carry,acc_i} <= acc_i + ftw_i (mod 2^ACC_WIDTH); ce_i <= carry.
//   ce registered: high the cycle after acc wraps; sq_i = acc_i[ACC_WIDTH-1] from register.
//  Writes in RUN: wr_en -> shadow[wr_ch]<=wr_ftw, pending[wr_ch]<=1; wr_ch>=CHANNELS ignored.
//   Applied (ftw<=shadow, pending<=0) on the edge where channel wraps (carry=1), or next edge if ftw_i=0.
//   Write on same edge as wrap: new wr_ftw bypasses to ftw directly, pending stays 0.
//   Back-to-back writes before wrap: last one wins.
//  ftw=0: channel frozen, ce_i never asserts, sq_i holds.
//  phase_sync in RUN: all acc<=0, ce<=0 that edge; pending words applied on same edge.
//   phase_sync outside RUN ignored. Takes priority over normal accumulate.
//  lock loss: ready falls the edge lock_s is seen low; acc/ce cleared same edge; ftw retained.
//  lost_clear clears lock_lost; simultaneous set and clear -> set wins.
//  rst mid-operation: immediate return to reset values incl. ftw/shadow; relock sequence repeats.
// TESTING
//  ACC_WIDTH=8, LOCK_HOLD=4, SYNC_STAGES=2: pll_lock 0->1 -> ready rises exactly 6 edges later; ce all 0 before.
//  ch0 ftw=64 in RUN -> ce0 every 4th cycle, sq0 2 high/2 low; ftw=0 on ch1 -> ce1 never, sq1 low.
//  ch0 at 64, write 128 mid-period -> pending0=1, current period completes, then ce0 every 2 cycles, pending0=0.
//  Write coincident with ch0 wrap -> new word active next cycle, pending0 never rises; wr_ch=5 (CHANNELS=4) ignored.
//  ch0=64, ch1=32 running, phase_sync -> both acc=0; ce0 at +4, ce1 at +8, coincident every 8 cycles.
//  Drop pll_lock in RUN -> ready low 2-3 edges later, ce/sq 0, lock_lost=1; lost_clear -> 0; relock restores same ftw.

Source files
------------

// File: rtl/clock_enable_gen.sv
// clock_enable_gen: lock-qualified multi-channel NCO clock-enable generator.
// Channels idle until the synchronised PLL lock has held for LOCK_HOLD cycles.
module clock_enable_gen #(
    parameter int CHANNELS    = 4,
    parameter int ACC_WIDTH   = 24,
    parameter int LOCK_HOLD   = 1024,
    parameter int SYNC_STAGES = 2,
    parameter int CH_W        = $clog2(CHANNELS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pll_lock,
    input  logic                 wr_en,
    input  logic [CH_W-1:0]      wr_ch,
    input  logic [ACC_WIDTH-1:0] wr_ftw,
    input  logic                 phase_sync,
    input  logic                 lost_clear,
    output logic                 ready,
    output logic                 lock_lost,
    output logic [CHANNELS-1:0]  pending,
    output logic [CHANNELS-1:0]  ce,
    output logic [CHANNELS-1:0]  sq
);
    localparam int CNT_W = $clog2(LOCK_HOLD + 1);

    typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

    state_t                 state, next_state;
    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   lock_s, act;

    assign lock_s = sync[SYNC_STAGES-1];
    assign act    = state == RUN && lock_s;
    assign ready  = state == RUN;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync      <= '0;
            state     <= WAIT_LOCK;
            cnt       <= '0;
            lock_lost <= 1'b0;
        end else begin
            sync      <= {sync[SYNC_STAGES-2:0], pll_lock};
            state     <= next_state;
            cnt       <= (state == SETTLE && lock_s) ? cnt + 1'b1 : '0;
            lock_lost <= (state == RUN && !lock_s) || (lock_lost && !lost_clear);
        end
    end

    always_comb begin
        next_state = WAIT_LOCK;
        if (lock_s)
            next_state = (state == WAIT_LOCK) ? SETTLE :
                         (state == RUN || cnt == CNT_W'(LOCK_HOLD - 1)) ? RUN : SETTLE;
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [ACC_WIDTH-1:0] acc, ftw, shadow;
        logic [ACC_WIDTH:0]   sum;
        logic                 hit, apply, ce_r, pend_r;

        assign hit = wr_en && wr_ch == CH_W'(g);
        assign sum = {1'b0, acc} + {1'b0, ftw};
        // Idle, resync and wrap are the only safe points to swap the word; a frozen channel never wraps
        assign apply = !act || phase_sync || sum[ACC_WIDTH] || (ftw == '0 && pend_r);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                acc    <= '0;
                ftw    <= '0;
                shadow <= '0;
                ce_r   <= 1'b0;
                pend_r <= 1'b0;
            end else begin
                acc    <= (act && !phase_sync) ? sum[ACC_WIDTH-1:0] : '0;
                ce_r   <= act && !phase_sync && sum[ACC_WIDTH];
                shadow <= hit ? wr_ftw : shadow;
                ftw    <= apply ? (hit ? wr_ftw : shadow) : ftw;
                pend_r <= !apply && (hit || pend_r);
            end
        end

        assign ce[g]      = ce_r;
        assign sq[g]      = acc[ACC_WIDTH-1];
        assign pending[g] = pend_r;
    end
endmodule

// File: tb/tb_clock_enable_gen.sv
// tb_clock_enable_gen: scoreboard bench; expected ce/sq/pending/ready come from
// closed-form NCO arithmetic or hand-derived tables, queued per cycle.
module tb_clock_enable_gen;
    localparam int CHN = 4, AW = 8, LH = 4, SS = 2, CW = 3;

    logic          clk = 1'b0;
    logic          rst, pll_lock, wr_en, phase_sync, lost_clear;
    logic [CW-1:0] wr_ch;
    logic [AW-1:0] wr_ftw;
    logic          ready, lock_lost;
    logic [CHN-1:0] pending, ce, sq;

    int errors = 0;
    int checks = 0;
    int f[4];

    typedef struct {
        logic       rdy;
        logic [3:0] ce;
        logic [3:0] sq;
        logic [3:0] pend;
    } exp_t;
    exp_t q[$];

    always #5 clk = ~clk;

    clock_enable_gen #(
        .CHANNELS(CHN), .ACC_WIDTH(AW), .LOCK_HOLD(LH), .SYNC_STAGES(SS), .CH_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock), .wr_en(wr_en), .wr_ch(wr_ch),
        .wr_ftw(wr_ftw), .phase_sync(phase_sync), .lost_clear(lost_clear),
        .ready(ready), .lock_lost(lock_lost), .pending(pending), .ce(ce), .sq(sq)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // n cycles after all accumulators were zero, running with tuning words f[]
    function automatic exp_t nco(int n);
        exp_t e;
        e.rdy = 1'b1; e.pend = '0; e.ce = '0; e.sq = '0;
        for (int c = 0; c < 4; c++) begin
            e.ce[c] = (n > 0) && ((f[c] * n) / 256 > (f[c] * (n - 1)) / 256);
            e.sq[c] = ((f[c] * n) % 256) >= 128;
        end
        return e;
    endfunction

    task automatic test_reset();
        rst = 1; pll_lock = 0; wr_en = 0; wr_ch = '0; wr_ftw = '0;
        phase_sync = 0; lost_clear = 0;
        repeat (2) cyc();
        checks++;
        if ({ready, lock_lost, pending, ce, sq} !== '0) begin
            errors++;
            $display("FAIL reset outputs got=%b_%b_%b_%b_%b exp=all zero", ready, lock_lost, pending, ce, sq);
        end
        rst = 0;
        cyc();
        wr_en = 1; wr_ch = 0; wr_ftw = 64; cyc();
        wr_ch = 2; wr_ftw = 96; cyc();
        wr_en = 0;
        checks++;
        if (pending !== '0 || ce !== '0) begin
            errors++;
            $display("FAIL idle_write pending=%b ce=%b exp pending=0000 ce=0000", pending, ce);
        end
        f = '{64, 0, 96, 0};
    endtask

    task automatic test_lock();
        exp_t e;
        pll_lock = 1;
        for (int k = 1; k <= SS + LH + 1; k++) begin
            e.rdy = (k == SS + LH + 1); e.ce = '0; e.sq = '0; e.pend = '0;
            q.push_back(e);
            cyc();
            e = q.pop_front();
            checks++;
            if ({ready, ce, sq, pending} !== {e.rdy, e.ce, e.sq, e.pend}) begin
                errors++;
                $display("FAIL lock edge=%0d rdy/ce/sq/pend got=%b_%b_%b_%b exp=%b_%b_%b_%b",
                         k, ready, ce, sq, pending, e.rdy, e.ce, e.sq, e.pend);
            end
        end
    endtask

    task automatic test_nco(input int cycles);
        exp_t e;
        for (int n = 1; n <= cycles; n++) begin
            q.push_back(nco(n));
            cyc();
            e = q.pop_front();
            checks++;
            if ({ready, ce, sq, pending} !== {e.rdy, e.ce, e.sq, e.pend}) begin
                errors++;
                $display("FAIL nco n=%0d rdy/ce/sq/pend got=%b_%b_%b_%b exp=%b_%b_%b_%b",
                         n, ready, ce, sq, pending, e.rdy, e.ce, e.sq, e.pend);
            end
        end
    endtask

    task automatic test_update();
        int   ce_t[8] = '{0, 0, 0, 1, 0, 1, 0, 1};
        int   sq_t[8] = '{0, 1, 1, 0, 1, 0, 1, 0};
        int   pd_t[8] = '{0, 1, 1, 0, 0, 0, 0, 0};
        exp_t e;
        for (int k = 0; k <= 8; k++) begin
            phase_sync = (k == 0);
            wr_en = (k == 2); wr_ch = 0; wr_ftw = 128;
            e = nco(k);
            if (k > 0) begin
                e.ce[0] = 1'(ce_t[k-1]); e.sq[0] = 1'(sq_t[k-1]); e.pend[0] = 1'(pd_t[k-1]);
            end
            q.push_back(e);
            cyc();
            e = q.pop_front();
            checks++;
            if ({ready, ce, sq, pending} !== {e.rdy, e.ce, e.sq, e.pend}) begin
                errors++;
                $display("FAIL update k=%0d rdy/ce/sq/pend got=%b_%b_%b_%b exp=%b_%b_%b_%b",
                         k, ready, ce, sq, pending, e.rdy, e.ce, e.sq, e.pend);
            end
        end
        phase_sync = 0; wr_en = 0;
        f[0] = 128;
    endtask

    task automatic test_back_to_back();
        int   ce_t[12] = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1};
        int   sq_t[12] = '{1, 0, 0, 1, 1, 0, 0, 1, 1, 0, 1, 0};
        int   pd_t[12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        exp_t e;
        for (int k = 0; k <= 12; k++) begin
            phase_sync = (k == 0);
            wr_en  = (k == 2 || k == 4 || k == 7 || k == 8);
            wr_ch  = (k == 4) ? 3'd5 : 3'd0;
            wr_ftw = (k == 2) ? 8'd64 : (k == 4) ? 8'd8 : (k == 7) ? 8'd32 : 8'd128;
            e = nco(k);
            if (k > 0) begin
                e.ce[0] = 1'(ce_t[k-1]); e.sq[0] = 1'(sq_t[k-1]); e.pend[0] = 1'(pd_t[k-1]);
            end
            q.push_back(e);
            cyc();
            e = q.pop_front();
            checks++;
            if ({ready, ce, sq, pending} !== {e.rdy, e.ce, e.sq, e.pend}) begin
                errors++;
                $display("FAIL b2b k=%0d rdy/ce/sq/pend got=%b_%b_%b_%b exp=%b_%b_%b_%b",
                         k, ready, ce, sq, pending, e.rdy, e.ce, e.sq, e.pend);
            end
        end
        phase_sync = 0; wr_en = 0;
        f[0] = 128;
    endtask

    task automatic test_phase_sync();
        exp_t e;
        wr_en = 1; wr_ch = 0; wr_ftw = 64; cyc();
        wr_ch = 1; wr_ftw = 32; cyc();
        wr_en = 0;
        f = '{64, 32, 96, 0};
        for (int k = 0; k <= 16; k++) begin
            phase_sync = (k == 0);
            q.push_back(nco(k));
            cyc();
            e = q.pop_front();
            checks++;
            if ({ready, ce, sq, pending} !== {e.rdy, e.ce, e.sq, e.pend}) begin
                errors++;
                $display("FAIL psync k=%0d rdy/ce/sq/pend got=%b_%b_%b_%b exp=%b_%b_%b_%b",
                         k, ready, ce, sq, pending, e.rdy, e.ce, e.sq, e.pend);
            end
        end
        phase_sync = 0;
    endtask

    task automatic test_lock_loss();
        int edges = 0;
        bit fell  = 0;
        pll_lock = 0;
        while (!fell && edges < 6) begin
            cyc();
            edges++;
            if (ready === 1'b0) fell = 1;
        end
        checks++;
        if (!fell || edges < 2 || edges > 3) begin
            errors++;
            $display("FAIL lockloss_latency edges=%0d fell=%0d exp 2..3 edges", edges, fell);
        end
        checks++;
        if ({lock_lost, ce, sq} !== {1'b1, 8'h00}) begin
            errors++;
            $display("FAIL lockloss_state lost/ce/sq got=%b_%b_%b exp=1_0000_0000", lock_lost, ce, sq);
        end
        lost_clear = 1; cyc(); lost_clear = 0;
        checks++;
        if (lock_lost !== 1'b0) begin
            errors++;
            $display("FAIL lost_clear lock_lost got=%b exp=0", lock_lost);
        end
        repeat (4) cyc();
        test_lock();
        test_nco(8);
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #3 rst = 1;
        #1;
        checks++;
        if ({ready, lock_lost, pending, ce, sq} !== '0) begin
            errors++;
            $display("FAIL async_reset got=%b_%b_%b_%b_%b exp=all zero", ready, lock_lost, pending, ce, sq);
        end
        cyc();
        rst = 0;
        f = '{0, 0, 0, 0};
        test_lock();
        test_nco(8);
    endtask

    initial begin
        test_reset();
        test_lock();
        test_nco(12);
        test_update();
        test_back_to_back();
        test_phase_sync();
        test_lock_loss();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
